// File: rtl/iroot_unit.sv
// Iterative integer cube/square root: one result digit per clock cycle,
// producing floor(a^(1/3)) or floor(sqrt(a)) together with the remainder.
module iroot_unit #(
  parameter int unsigned W = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [W-1:0]         a_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [(W+1)/2-1:0]   y_bo,
  output logic [W-1:0]         r_bo
);

  localparam int unsigned YW  = (W + 1) / 2;
  localparam int unsigned NCB = (W + 2) / 3;
  localparam int unsigned NSQ = (W + 1) / 2;
  localparam int unsigned CW  = $clog2(NSQ);
  // Wide enough for 3y(y+1)+1 of a YW-bit root shifted by up to W-1 places.
  localparam int unsigned BW  = 2 * YW + 2 + W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x_q, x_d;
  logic [YW-2:0]   y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [YW-1:0]   yres_q, yres_d;
  logic [W-1:0]    rres_q, rres_d;

  logic [BW-1:0]   y2_w;
  logic [BW-1:0]   base_s;
  logic [BW-1:0]   b_s;
  logic [CW+1:0]   sh_s;
  logic            ge_s;
  logic [W-1:0]    x_it_s;
  logic [YW-1:0]   y_it_s;

  // Digit datapath: trial subtrahend, compare and conditional subtract.
  always_comb begin
    y2_w   = {{(BW-YW){1'b0}}, y_q, 1'b0};
    sh_s   = {(CW+2){1'b0}};
    base_s = {BW{1'b0}};
    if (mode_q) begin
      sh_s   = {1'b0, cnt_q, 1'b0};
      base_s = {y2_w[BW-2:0], 1'b1};
    end else begin
      sh_s   = {2'b00, cnt_q} + {1'b0, cnt_q, 1'b0};
      base_s = BW'(2'd3) * y2_w * (y2_w + BW'(1'b1)) + BW'(1'b1);
    end
    b_s    = base_s << sh_s;
    ge_s   = ({{(BW-W){1'b0}}, x_q} >= b_s);
    y_it_s = {y_q, ge_s};
    if (ge_s) begin
      x_it_s = x_q - b_s[W-1:0];
    end else begin
      x_it_s = x_q;
    end
  end

  // Control FSM next-state and result capture.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    yres_d  = yres_q;
    rres_d  = rres_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CALC;
          x_d     = a_i;
          y_d     = {(YW-1){1'b0}};
          mode_d  = mode_i;
          busy_d  = 1'b1;
          if (mode_i) begin
            cnt_d = CW'(NSQ - 1);
          end else begin
            cnt_d = CW'(NCB - 1);
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      CALC: begin
        x_d = x_it_s;
        y_d = y_it_s[YW-2:0];
        if (cnt_q == {CW{1'b0}}) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          yres_d  = y_it_s;
          rres_d  = x_it_s;
        end else begin
          cnt_d = cnt_q - CW'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= {W{1'b0}};
      y_q     <= {(YW-1){1'b0}};
      cnt_q   <= {CW{1'b0}};
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      yres_q  <= {YW{1'b0}};
      rres_q  <= {W{1'b0}};
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      yres_q  <= yres_d;
      rres_q  <= rres_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign y_bo   = yres_q;
  assign r_bo   = rres_q;

endmodule

// File: tb/tb_iroot_unit.sv
// Directed bench for iroot_unit: W=9 and W=16 instances sharing one clock,
// expected roots/remainders computed by hand.
module tb_iroot_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start9, mode9, start16, mode16;
  logic [8:0]  a9;
  logic [15:0] a16;
  logic        busy9, done9, busy16, done16;
  logic [4:0]  y9;
  logic [8:0]  r9;
  logic [7:0]  y16;
  logic [15:0] r16;

  int checks = 0;
  int errors = 0;
  bit sel;
  logic [31:0] last_y [2];
  logic [31:0] last_r [2];

  logic        cur_busy, cur_done;
  logic [31:0] cur_y, cur_r;
  assign cur_busy = sel ? busy16 : busy9;
  assign cur_done = sel ? done16 : done9;
  assign cur_y    = sel ? 32'(y16) : 32'(y9);
  assign cur_r    = sel ? 32'(r16) : 32'(r9);

  iroot_unit #(.W(9)) dut9 (
    .clk_i(clk), .rst_i(rst), .start_i(start9), .mode_i(mode9), .a_i(a9),
    .busy_o(busy9), .done_o(done9), .y_bo(y9), .r_bo(r9)
  );

  iroot_unit #(.W(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .mode_i(mode16), .a_i(a16),
    .busy_o(busy16), .done_o(done16), .y_bo(y16), .r_bo(r16)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One computation; optional injected start with a different operand mid-run.
  task automatic root(input bit w16, input bit md, input logic [15:0] a,
                      input int ey, input int er, input int en, input bit inj);
    int cyc;
    int idx;
    idx = w16 ? 1 : 0;
    sel = w16;
    @(negedge clk);
    start9 = !w16; start16 = w16; mode9 = md; mode16 = md;
    a9 = a[8:0]; a16 = a;
    @(negedge clk);
    start9 = 1'b0; start16 = 1'b0;
    cyc = 0;
    while (cur_busy && cyc < 40) begin
      cyc++;
      check_eq("hold_done", 32'(cur_done), 32'd0);
      check_eq("hold_y", cur_y, last_y[idx]);
      check_eq("hold_r", cur_r, last_r[idx]);
      if (inj && cyc == 1) begin
        start9 = !w16; start16 = w16; mode9 = ~md; mode16 = ~md;
        a9 = ~a9; a16 = ~a16;
      end else begin
        start9 = 1'b0; start16 = 1'b0;
      end
      @(negedge clk);
    end
    start9 = 1'b0; start16 = 1'b0;
    check_eq("busy_cycles", 32'(cyc), 32'(en));
    check_eq("done_pulse", 32'(cur_done), 32'd1);
    check_eq("root_y", cur_y, 32'(ey));
    check_eq("root_r", cur_r, 32'(er));
    last_y[idx] = 32'(ey);
    last_r[idx] = 32'(er);
    @(negedge clk);
    check_eq("done_once", 32'(cur_done), 32'd0);
    check_eq("idle_busy", 32'(cur_busy), 32'd0);
  endtask

  int cube_a [10] = '{0, 1, 2, 8, 9, 28, 68, 125, 255, 511};
  int cube_y [10] = '{0, 1, 1, 2, 2, 3, 4, 5, 6, 7};
  int cube_r [10] = '{0, 0, 1, 0, 1, 1, 4, 0, 39, 168};
  int sq_a [5] = '{0, 1, 4, 255, 511};
  int sq_y [5] = '{0, 1, 2, 15, 22};
  int sq_r [5] = '{0, 0, 0, 30, 27};

  initial begin
    rst = 1'b1; start9 = 1'b0; start16 = 1'b0; mode9 = 1'b0; mode16 = 1'b0;
    a9 = 9'd0; a16 = 16'd0; sel = 1'b0;
    last_y[0] = 32'd0; last_r[0] = 32'd0; last_y[1] = 32'd0; last_r[1] = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy9", 32'(busy9), 32'd0);
    check_eq("rst_done9", 32'(done9), 32'd0);
    check_eq("rst_y9", 32'(y9), 32'd0);
    check_eq("rst_r9", 32'(r9), 32'd0);
    check_eq("rst_busy16", 32'(busy16), 32'd0);
    check_eq("rst_y16", 32'(y16), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) root(1'b0, 1'b0, 16'(cube_a[i]), cube_y[i], cube_r[i], 3, 1'b0);
    for (int i = 0; i < 5; i++) root(1'b0, 1'b1, 16'(sq_a[i]), sq_y[i], sq_r[i], 5, 1'b0);
    root(1'b1, 1'b0, 16'd65535, 40, 1535, 6, 1'b0);
    root(1'b1, 1'b1, 16'd65535, 255, 510, 8, 1'b0);

    // Start pulse with another operand during CALC must be ignored.
    root(1'b0, 1'b0, 16'd125, 5, 0, 3, 1'b1);

    // Reset in the middle of a computation.
    sel = 1'b0;
    @(negedge clk);
    start9 = 1'b1; mode9 = 1'b0; a9 = 9'd511;
    @(negedge clk);
    start9 = 1'b0;
    check_eq("mid_busy", 32'(busy9), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy9), 32'd0);
    check_eq("abort_done", 32'(done9), 32'd0);
    check_eq("abort_y", 32'(y9), 32'd0);
    check_eq("abort_r", 32'(r9), 32'd0);
    last_y[0] = 32'd0; last_r[0] = 32'd0; last_y[1] = 32'd0; last_r[1] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("abort_nodone", 32'(done9), 32'd0);
    end
    root(1'b0, 1'b0, 16'd511, 7, 168, 3, 1'b0);

    // Start held high: results every N+1 = 4 cycles.
    @(negedge clk);
    start9 = 1'b1; mode9 = 1'b0; a9 = 9'd255;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_eq("b2b_done", 32'(done9), 32'((k % 4) == 3));
      check_eq("b2b_busy", 32'(busy9), 32'((k % 4) != 3));
      if ((k % 4) == 3) begin
        check_eq("b2b_y", 32'(y9), 32'd6);
        check_eq("b2b_r", 32'(r9), 32'd39);
      end
    end
    start9 = 1'b0;
    @(negedge clk);
    check_eq("b2b_stop", 32'(busy9), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iroot_unit.md
IROOT_UNIT -- requirements
Module: iroot_unit

Interface
REQ-001 Parameter W, default 9: operand width in bits; legal range 3..32.
REQ-002 Port clk_i  input  1  sole clock; all state changes on rising edge.
REQ-003 Port rst_i  input  1  reset; synchronous, active-high.
REQ-004 Port start_i  input  1  request to start a root computation; sampled only in IDLE.
REQ-005 Port mode_i  input  1  root type: 0 = cube root, 1 = square root; sampled with start_i.
REQ-006 Port a_i  input  W  unsigned radicand; sampled with start_i.
REQ-007 Port busy_o  output  1  high while a computation is in progress.
REQ-008 Port done_o  output  1  one-cycle pulse when a new result is valid.
REQ-009 Port y_bo  output  (W+1)/2 (integer division)  root result, floor(a^(1/3)) or floor(sqrt(a)), zero-extended.
REQ-010 Port r_bo  output  W  remainder: a - y^3 (cube) or a - y^2 (square).

Function
REQ-011 Two states: IDLE and CALC; reset state IDLE.
REQ-012 In IDLE with start_i=1 at a clock edge, the block latches a_i and mode_i, clears the internal root, loads the iteration counter, and enters CALC; busy_o reads 1 from the next cycle.
REQ-013 Iteration count N: cube N=ceil(W/3); square N=ceil(W/2); W=9 gives cube N=3 and square N=5.
REQ-014 Exactly one digit iteration per CALC cycle; busy_o stays high for exactly N cycles.
REQ-015 Cube iteration (shift s from 3*(N-1) down by 3): y=2y; b=(3y(y+1)+1)<<s; if x>=b then x=x-b, y=y+1.
REQ-016 Square iteration (shift s from 2*(N-1) down by 2): y=2y; b=(2y+1)<<s; if x>=b then x=x-b, y=y+1.
REQ-017 Compare and subtract are computed without truncation; internal b width is sufficient for every legal W, and b exceeding the W-bit range makes x>=b false.
REQ-018 On the final CALC edge, y_bo and r_bo load the result, busy_o goes 0, done_o goes 1, and the state returns to IDLE.
REQ-019 done_o is high for exactly one cycle per computation and is never high while busy_o is high.
REQ-020 y_bo and r_bo hold the last result unchanged during CALC and in IDLE until the next completion.
REQ-021 start_i is ignored while in CALC; a_i and mode_i changes during CALC do not affect the running computation.
REQ-022 start_i=1 in the cycle where done_o=1 (state IDLE) is accepted; back-to-back throughput is N+1 cycles per result.
REQ-023 a_i=0 yields y_bo=0 and r_bo=0 after the full N cycles; there is no early termination.

Reset
REQ-024 rst_i=1 at a clock edge forces IDLE, busy_o=0, done_o=0, y_bo=0, r_bo=0, and clears the internal x, y and counter.
REQ-025 Reset takes priority over start_i and over an in-progress CALC; the aborted computation produces no done_o pulse.
REQ-026 After rst_i deasserts, the first edge with start_i=1 starts a new computation normally.

Verification
REQ-027 W=9, cube: a = 0, 1, 2, 8, 9, 28, 68, 125, 255, 511 -> y = 0, 1, 1, 2, 2, 3, 4, 5, 6, 7; r for 511 = 168, r for 255 = 39; busy_o high for 3 cycles; one done_o pulse each.
REQ-028 W=9, square: a=255 -> y=15, r=30; a=511 -> y=22, r=27; busy_o high for 5 cycles.
REQ-029 W=16: cube a=65535 -> y=40, r=1535; square a=65535 -> y=255, r=510; busy_o high for 6 cycles (cube) and 8 cycles (square).
REQ-030 Pulse start_i with a different a_i mid-CALC -> ignored; result matches the first operand; one done_o only.
REQ-031 Assert rst_i for one cycle mid-CALC -> busy_o=0, y_bo=0, r_bo=0 next cycle, no done_o; a following start completes correctly.
REQ-032 Hold start_i high continuously -> back-to-back results every N+1 cycles, with done_o and the new busy_o period adjacent.
